// File: rtl/px_source_lfsr_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : px_source_lfsr_mux_pkg
// Description : Shared types and constants for the pixel source / LFSR mux.
// Revision    : 1.0 - initial release
// ============================================================================
package px_source_lfsr_mux_pkg;

    // Widest pixel the downstream gray/sobel core accepts
    localparam int c_MAX_PIXEL_BITS = 24;

    // x^16 + x^5 + x^3 + x^2 + 1 Galois feedback mask
    localparam logic [15:0] c_DEFAULT_TAPS = 16'h002D;

    // Source FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_CFG  = 2'd0;
    localparam state_t c_ST_IDLE = 2'd1;
    localparam state_t c_ST_RUN  = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/px_source_lfsr_mux_lfsr_galois.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_galois
// Description : Galois LFSR with parallel load and step enable. Load wins
//               over step when both are asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_galois #(
    parameter int                   LFSR_BITS = 16,
    parameter logic [LFSR_BITS-1:0] TAPS      = 16'h002D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [LFSR_BITS-1:0] i_load_value,
    input  logic                 i_step,
    output logic [LFSR_BITS-1:0] o_state
);

    logic [LFSR_BITS-1:0] r_state;
    logic [LFSR_BITS-1:0] w_next;

    // Shift left; fold the feedback mask in when the MSB falls out
    always_comb begin
        w_next = {r_state[LFSR_BITS-2:0], 1'b0};
        if (r_state[LFSR_BITS-1]) begin
            w_next = w_next ^ TAPS;
        end
    end

    // State register: load a new value or advance one step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_load_value;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/px_source_lfsr_mux.sv
`default_nettype none
// ============================================================================
// Module      : px_source_lfsr_mux
// Description : Pixel source in front of the gray/sobel core. Muxes the SPI
//               pixel stream with a paced Galois LFSR pattern generator whose
//               seed and stop code are loaded byte-serially.
// Revision    : 1.0 - initial release
// ============================================================================
module px_source_lfsr_mux
    import px_source_lfsr_mux_pkg::*;
#(
    parameter int                   PX_BITS     = c_MAX_PIXEL_BITS,
    parameter int                   LFSR_BITS   = 16,
    parameter logic [LFSR_BITS-1:0] TAPS        = c_DEFAULT_TAPS,
    parameter int                   PX_INTERVAL = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [7:0]         cfg_byte_i,
    input  logic               cfg_valid_i,
    input  logic               select_input_i,
    input  logic               start_i,
    input  logic [PX_BITS-1:0] ext_px_i,
    input  logic               ext_px_rdy_i,
    output logic [PX_BITS-1:0] px_o,
    output logic               px_rdy_o,
    output logic               cfg_loaded_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int c_CFG_BYTES = 2 * LFSR_BITS / 8;
    localparam int c_CNT_W     = $clog2(c_CFG_BYTES + 1);
    localparam int c_PACE_W    = (PX_INTERVAL > 1) ? $clog2(PX_INTERVAL) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST_BYTE = c_CNT_W'(c_CFG_BYTES - 1);
    localparam logic [c_PACE_W-1:0] c_PACE_LAST = c_PACE_W'(PX_INTERVAL - 1);
    localparam int c_SR_BITS   = 2 * LFSR_BITS;

    state_t                r_state;
    logic [c_SR_BITS-1:0]  r_cfg_sr;
    logic [c_CNT_W-1:0]    r_byte_cnt;
    logic [c_PACE_W-1:0]   r_pace;
    logic [PX_BITS-1:0]    r_px;
    logic                  r_px_rdy;
    logic                  r_cfg_loaded;
    logic                  r_busy;
    logic                  r_done;

    logic [LFSR_BITS-1:0]  w_seed;
    logic [LFSR_BITS-1:0]  w_stop;
    logic [LFSR_BITS-1:0]  w_lfsr;
    logic [LFSR_BITS-1:0]  w_load_value;
    logic [PX_BITS-1:0]    w_lfsr_px;
    logic [c_SR_BITS-1:0]  w_cfg_shifted;
    logic                  w_start_run;
    logic                  w_emit;
    logic                  w_hit_stop;

    // Seed occupies the upper half of the config shift register, stop code
    // the lower half, because bytes arrive seed-first, MSB byte first.
    assign w_seed        = r_cfg_sr[c_SR_BITS-1:LFSR_BITS];
    assign w_stop        = r_cfg_sr[LFSR_BITS-1:0];
    assign w_cfg_shifted = {r_cfg_sr[c_SR_BITS-9:0], cfg_byte_i};

    // Pixel bit i mirrors LFSR bit (i mod LFSR_BITS)
    for (genvar i = 0; i < PX_BITS; i++) begin : g_px_map
        assign w_lfsr_px[i] = w_lfsr[i % LFSR_BITS];
    end

    // Run entry, pixel emission and stop-code detection
    always_comb begin
        w_start_run  = (r_state == c_ST_IDLE) && !cfg_valid_i && start_i && select_input_i;
        w_emit       = (r_state == c_ST_RUN) && start_i && select_input_i && (r_pace == c_PACE_LAST);
        w_hit_stop   = (w_stop != '0) && (w_lfsr == w_stop);
        w_load_value = (w_seed == '0) ? LFSR_BITS'(1) : w_seed;
    end

    lfsr_galois #(
        .LFSR_BITS (LFSR_BITS),
        .TAPS      (TAPS)
    ) u_lfsr (
        .clk          (clk_i),
        .rst          (reset_i),
        .i_load       (w_start_run),
        .i_load_value (w_load_value),
        .i_step       (w_emit),
        .o_state      (w_lfsr)
    );

    // Control FSM: config loading, run pacing, stop detection
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= c_ST_CFG;
            r_cfg_sr     <= '0;
            r_byte_cnt   <= '0;
            r_pace       <= '0;
            r_cfg_loaded <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_CFG: begin
                    if (cfg_valid_i) begin
                        r_cfg_sr <= w_cfg_shifted;
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_byte_cnt   <= '0;
                            r_cfg_loaded <= 1'b1;
                            r_state      <= c_ST_IDLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                c_ST_IDLE: begin
                    // A new config byte always beats a start request
                    if (cfg_valid_i) begin
                        r_cfg_sr     <= w_cfg_shifted;
                        r_byte_cnt   <= c_CNT_W'(1);
                        r_cfg_loaded <= 1'b0;
                        r_state      <= c_ST_CFG;
                    end else if (w_start_run) begin
                        r_pace  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (!start_i) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else if (select_input_i) begin
                        if (w_emit) begin
                            r_pace <= '0;
                            if (w_hit_stop) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= c_ST_DONE;
                            end
                        end else begin
                            r_pace <= r_pace + 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (!start_i) begin
                        r_done  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_CFG;
                end
            endcase
        end
    end

    // Output mux: external stream when deselected, paced LFSR pixels otherwise
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_px     <= '0;
            r_px_rdy <= 1'b0;
        end else if (!select_input_i) begin
            r_px     <= ext_px_i;
            r_px_rdy <= ext_px_rdy_i;
        end else if (w_emit) begin
            r_px     <= w_lfsr_px;
            r_px_rdy <= 1'b1;
        end else begin
            r_px_rdy <= 1'b0;
        end
    end

    assign px_o         = r_px;
    assign px_rdy_o     = r_px_rdy;
    assign cfg_loaded_o = r_cfg_loaded;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_px_source_lfsr_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_px_source_lfsr_mux
// Description : Scoreboard bench for px_source_lfsr_mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_px_source_lfsr_mux;

    logic        r_clk = 1'b0;
    logic        r_reset = 1'b1;
    logic [7:0]  r_cfg_byte = 8'd0;
    logic        r_cfg_valid = 1'b0;
    logic        r_select = 1'b0;
    logic        r_start = 1'b0;
    logic [23:0] r_ext_px = 24'd0;
    logic        r_ext_rdy = 1'b0;
    logic [23:0] w_px;
    logic        w_px_rdy;
    logic        w_cfg_loaded;
    logic        w_busy;
    logic        w_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_rdy = -1;
    bit          chk_iv = 1'b0;
    logic [23:0] q_exp[$];
    logic [23:0] r_exp_px;
    logic [15:0] r_model;

    px_source_lfsr_mux dut (
        .clk_i          (r_clk),
        .reset_i        (r_reset),
        .cfg_byte_i     (r_cfg_byte),
        .cfg_valid_i    (r_cfg_valid),
        .select_input_i (r_select),
        .start_i        (r_start),
        .ext_px_i       (r_ext_px),
        .ext_px_rdy_i   (r_ext_rdy),
        .px_o           (w_px),
        .px_rdy_o       (w_px_rdy),
        .cfg_loaded_o   (w_cfg_loaded),
        .busy_o         (w_busy),
        .done_o         (w_done)
    );

    always #5 r_clk = ~r_clk;
    always @(posedge r_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], 1'b0} ^ (x[15] ? 16'h002D : 16'h0000);
    endfunction

    function automatic logic [23:0] px_of(input logic [15:0] l);
        return {l[7:0], l};
    endfunction

    // Scoreboard: every ready pulse must match the next expected pixel
    always @(negedge r_clk) begin
        if (w_px_rdy === 1'b1) begin
            if (q_exp.size() == 0) begin
                chk("rdy_unexpected", {31'd0, w_px_rdy}, 32'd0);
            end else begin
                r_exp_px = q_exp.pop_front();
                chk("px", {8'd0, w_px}, {8'd0, r_exp_px});
            end
            if (chk_iv && last_rdy >= 0) chk("interval", cyc - last_rdy, 4);
            last_rdy = cyc;
        end
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        r_cfg_byte  = b;
        r_cfg_valid = 1'b1;
        tick();
        r_cfg_valid = 1'b0;
    endtask

    task automatic push_px(input int n);
        for (int i = 0; i < n; i++) begin
            q_exp.push_back(px_of(r_model));
            r_model = lfsr_next(r_model);
        end
    endtask

    task automatic wait_q_empty(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (q_exp.size() == 0) break;
            tick();
        end
        chk(tag, q_exp.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        r_reset = 1'b0;
        chk("rst_px", {8'd0, w_px}, 0);
        chk("rst_rdy", {31'd0, w_px_rdy}, 0);
        chk("rst_loaded", {31'd0, w_cfg_loaded}, 0);
        chk("rst_busy", {31'd0, w_busy}, 0);
        chk("rst_done", {31'd0, w_done}, 0);

        // Seed 0x0001, stop 0x002D: 17 pixels then DONE
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        chk("loaded_partial", {31'd0, w_cfg_loaded}, 0);
        send_byte(8'h2D);
        chk("loaded", {31'd0, w_cfg_loaded}, 1);
        r_model = 16'h0001;
        push_px(17);
        chk_iv = 1'b1; last_rdy = -1;
        r_select = 1'b1; r_start = 1'b1;
        tick(); tick();
        chk("busy_run", {31'd0, w_busy}, 1);
        wait_q_empty("stop_seq", 200);
        chk("done_set", {31'd0, w_done}, 1);
        chk("busy_clr", {31'd0, w_busy}, 0);
        repeat (12) tick();
        chk("done_hold", {31'd0, w_done}, 1);
        r_start = 1'b0;
        tick(); tick();
        chk("done_clr", {31'd0, w_done}, 0);

        // Zero seed / zero stop: free-run from 1
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("loaded_zero", {31'd0, w_cfg_loaded}, 1);
        r_model = 16'h0001;
        push_px(100);
        last_rdy = -1;
        r_start = 1'b1;
        wait_q_empty("free_run", 1000);
        chk("free_no_done", {31'd0, w_done}, 0);
        chk("free_busy", {31'd0, w_busy}, 1);
        r_start = 1'b0;
        tick(); tick();

        // External path in the middle of a run; LFSR must hold
        chk_iv = 1'b0;
        r_model = 16'h0001;
        push_px(2);
        r_start = 1'b1;
        wait_q_empty("pre_ext", 40);
        r_select = 1'b0;
        tick();
        r_ext_px = 24'hABCDEF; r_ext_rdy = 1'b1;
        q_exp.push_back(24'hABCDEF);
        tick();
        r_ext_rdy = 1'b0;
        chk("ext_rdy", {31'd0, w_px_rdy}, 1);
        chk("ext_px", {8'd0, w_px}, 32'h00ABCDEF);
        tick();
        chk("ext_rdy_low", {31'd0, w_px_rdy}, 0);
        repeat (5) tick();
        chk("ext_px_hold", {8'd0, w_px}, 32'h00ABCDEF);
        // Re-select LFSR while the SPI side keeps pulsing; those must be dropped
        r_ext_px = 24'h123456; r_ext_rdy = 1'b1;
        r_select = 1'b1;
        push_px(2);
        wait_q_empty("post_ext", 40);
        r_ext_rdy = 1'b0;

        // Drop start mid-run, then reload and restart from the seed
        r_start = 1'b0;
        tick(); tick();
        chk("stop_busy", {31'd0, w_busy}, 0);
        chk("stop_done", {31'd0, w_done}, 0);
        repeat (12) tick();
        send_byte(8'hAC); send_byte(8'hE1); send_byte(8'h00); send_byte(8'h00);
        r_model = 16'hACE1;
        push_px(3);
        chk_iv = 1'b1; last_rdy = -1;
        r_start = 1'b1;
        wait_q_empty("run3", 60);
        r_start = 1'b0;
        tick(); tick();
        chk("drop_busy", {31'd0, w_busy}, 0);
        chk("drop_done", {31'd0, w_done}, 0);
        repeat (12) tick();
        r_model = 16'hACE1;
        push_px(2);
        last_rdy = -1;
        r_start = 1'b1;
        wait_q_empty("restart", 60);
        r_start = 1'b0;
        tick(); tick();

        // Config byte together with start rising: loader wins
        chk_iv = 1'b0;
        r_start = 1'b1;
        send_byte(8'hFF);
        chk("cfg_prio_loaded", {31'd0, w_cfg_loaded}, 0);
        repeat (8) tick();
        chk("cfg_prio_busy", {31'd0, w_busy}, 0);
        r_start = 1'b0;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("reload", {31'd0, w_cfg_loaded}, 1);

        // Reset in the middle of a run
        r_model = 16'hFF00;
        push_px(1);
        r_start = 1'b1;
        wait_q_empty("pre_reset", 40);
        tick();
        r_reset = 1'b1;
        tick();
        r_reset = 1'b0;
        chk("mid_rst_px", {8'd0, w_px}, 0);
        chk("mid_rst_rdy", {31'd0, w_px_rdy}, 0);
        chk("mid_rst_loaded", {31'd0, w_cfg_loaded}, 0);
        chk("mid_rst_busy", {31'd0, w_busy}, 0);
        chk("mid_rst_done", {31'd0, w_done}, 0);
        repeat (12) tick();
        chk("cfg_no_run", {31'd0, w_busy}, 0);
        r_start = 1'b0;
        tick();
        chk("q_final", q_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
